// File: rtl/spi_slave_regfile_pkg.sv
// Shared command encodings and FSM state type for the SPI register-file responder.
package spi_pkg;

    localparam logic CMD_WR = 1'b1;
    localparam logic CMD_RD = 1'b0;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

endpackage

// File: rtl/spi_slave_regfile_sync_edge.sv
// Two-flop synchroniser for an asynchronous input with a third flop for edge detection.
module spi_sync_edge (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0],[1] synchronise; [2] holds the previous synchronised level
    logic [2:0] sync_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_regfile.sv
// Oversampled mode-0 SPI responder backed by a 2^A x D register file.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN releases MISO while SS is high.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int unsigned D = 8,
    parameter int unsigned A = 4
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         SS,
    input  logic         SCLK,
    input  logic         MOSI,
    output logic         MISO,
    output logic         WR_STB,
    output logic [A-1:0] WR_ADDR,
    output logic [D-1:0] WR_DATA,
    output logic         FRAME_ERR,
    input  logic [A-1:0] LOC_ADDR,
    output logic [D-1:0] LOC_DATAO
);

    localparam int unsigned   CW        = $clog2((A > D) ? A : D) + 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(A - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(D - 1);
    localparam int unsigned   DEPTH     = 2 ** A;

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_sync_ss (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .din     (SS),
        .level   (ss_lvl),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    spi_sync_edge u_sync_sclk (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .din     (SCLK),
        .level   (sclk_lvl_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge u_sync_mosi (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .din     (MOSI),
        .level   (mosi_lvl),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_init;
    logic          cnt_zero, cnt_load, cnt_dec;
    logic          armed_q, cmd_q, miso_q;
    logic [A-1:0]  addr_q, rd_addr;
    logic [D-2:0]  data_q;
    logic [D-1:0]  shout_q, rd_word;
    logic          wr_stb_q, frame_err_q;
    logic [A-1:0]  wr_addr_q;
    logic [D-1:0]  wr_data_q;
    logic [D-1:0]  regs_q [DEPTH];

    logic start, abort, commit, latch_cmd, shift_addr, shift_data, load_out, shift_out;

    assign cnt_zero = (cnt_q == '0);
    // Address including the bit arriving on the final address rise
    assign rd_addr  = A'({addr_q, mosi_lvl});
    assign rd_word  = regs_q[rd_addr];

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ss_fall && armed_q) state_d = CMD;
            CMD: begin
                if (ss_rise)        state_d = IDLE;
                else if (sclk_rise) state_d = ADDR;
            end
            ADDR: begin
                if (ss_rise)                    state_d = IDLE;
                else if (sclk_rise && cnt_zero) state_d = DATA;
            end
            DATA: begin
                if (ss_rise)                    state_d = IDLE;
                else if (sclk_rise && cnt_zero) state_d = DONE;
            end
            DONE: if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start      = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
        latch_cmd  = 1'b0;
        shift_addr = 1'b0;
        shift_data = 1'b0;
        load_out   = 1'b0;
        shift_out  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_init   = '0;
        unique case (state_q)
            IDLE: begin
                start    = ss_fall && armed_q;
                cnt_load = ss_fall && armed_q;
            end
            CMD: begin
                abort = ss_rise;
                if (!ss_rise && sclk_rise) begin
                    latch_cmd = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_init  = ADDR_LAST;
                end
            end
            ADDR: begin
                abort = ss_rise;
                if (!ss_rise && sclk_rise) begin
                    shift_addr = 1'b1;
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        cnt_init = DATA_LAST;
                        load_out = (cmd_q == CMD_RD);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            DATA: begin
                abort = ss_rise;
                if (!ss_rise) begin
                    if (sclk_rise) begin
                        shift_data = 1'b1;
                        commit     = cnt_zero && (cmd_q == CMD_WR);
                        cnt_dec    = !cnt_zero;
                    end
                    // The fall ahead of the first data rise keeps the preloaded MSB
                    shift_out = sclk_fall && (cmd_q == CMD_RD) && (cnt_q != DATA_LAST);
                end
            end
            DONE: ;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            cmd_q       <= CMD_RD;
            addr_q      <= '0;
            data_q      <= '0;
            shout_q     <= '0;
            miso_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_stb_q    <= commit;
            frame_err_q <= abort;
            if (commit) begin
                wr_addr_q <= addr_q;
                wr_data_q <= {data_q, mosi_lvl};
            end
            if (ss_rise)    armed_q <= 1'b1;
            else if (start) armed_q <= 1'b0;
            if (cnt_load)     cnt_q <= cnt_init;
            else if (cnt_dec) cnt_q <= cnt_q - CW'(1);
            if (latch_cmd)  cmd_q  <= mosi_lvl;
            if (shift_addr) addr_q <= A'({addr_q, mosi_lvl});
            if (shift_data) data_q <= (D-1)'({data_q, mosi_lvl});
            if (load_out)       shout_q <= rd_word;
            else if (shift_out) shout_q <= shout_q << 1;
            if (ss_rise || state_q == IDLE) miso_q <= 1'b0;
            else if (load_out)              miso_q <= rd_word[D-1];
            else if (shift_out)             miso_q <= shout_q[D-2];
        end
    end

    // Array is written one cycle after the strobe appears on the write port
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
        end else if (wr_stb_q) begin
            regs_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign WR_STB    = wr_stb_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign FRAME_ERR = frame_err_q;
    assign LOC_DATAO = regs_q[LOC_ADDR];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = ss_lvl ? 1'bz : miso_q;
`else
    logic ss_lvl_unused;
    assign ss_lvl_unused = ss_lvl;
    assign MISO          = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: writes, reads, aborts, back-to-back and mid-frame reset.
module tb_spi_slave_regfile;

    localparam int unsigned D = 8;
    localparam int unsigned A = 4;

    logic         CLOCK = 1'b0;
    logic         RESET_N, SS, SCLK, MOSI;
    logic         MISO, WR_STB, FRAME_ERR;
    logic [A-1:0] WR_ADDR, LOC_ADDR;
    logic [D-1:0] WR_DATA, LOC_DATAO;

    always #5 CLOCK = ~CLOCK;

    spi_slave_regfile #(.D(D), .A(A)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .SS        (SS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .WR_STB    (WR_STB),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .FRAME_ERR (FRAME_ERR),
        .LOC_ADDR  (LOC_ADDR),
        .LOC_DATAO (LOC_DATAO)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Strobe monitor
    int           wr_cnt = 0;
    int           fe_cnt = 0;
    int           stb_multi = 0;
    logic         stb_prev = 1'b0;
    logic [A-1:0] last_wa = '0;
    logic [D-1:0] last_wd = '0;

    always @(negedge CLOCK) begin
        if (WR_STB) begin
            wr_cnt++;
            last_wa = WR_ADDR;
            last_wd = WR_DATA;
            if (stb_prev) stb_multi++;
        end
        if (FRAME_ERR) fe_cnt++;
        stb_prev = WR_STB;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SCLK = CLOCK/10; MOSI changes on the fall, MISO captured just before each data rise
    task automatic spi_bits(input logic [12:0] bits, input int first, input int last,
                            output logic [7:0] rd);
        rd = '0;
        for (int i = first; i <= last; i++) begin
            SCLK = 1'b0;
            MOSI = bits[12-i];
            clks(5);
            if (i >= 5) rd = {rd[6:0], MISO};
            SCLK = 1'b1;
            clks(5);
        end
        SCLK = 1'b0;
        clks(5);
    endtask

    task automatic frame(input logic cmd, input logic [3:0] addr, input logic [7:0] data,
                         input int nbits, output logic [7:0] rd, output logic hold);
        SS = 1'b0;
        clks(5);
        spi_bits({cmd, addr, data}, 0, nbits - 1, rd);
        hold = MISO;
        SS = 1'b1;
        clks(20);
    endtask

    logic [7:0] rd;
    logic       hold;
    int         wr_base, fe_base;

    initial begin
        RESET_N  = 1'b0;
        SS       = 1'b1;
        SCLK     = 1'b0;
        MOSI     = 1'b0;
        LOC_ADDR = '0;
        clks(3);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_wr_stb", 32'(WR_STB), 32'd0);
        check("rst_frame_err", 32'(FRAME_ERR), 32'd0);
        check("rst_wr_addr", 32'(WR_ADDR), 32'd0);
        check("rst_wr_data", 32'(WR_DATA), 32'd0);
        check("rst_loc0", 32'(LOC_DATAO), 32'd0);
        RESET_N = 1'b1;
        clks(10);

        // Read address 3 straight after reset
        wr_base = wr_cnt;
        frame(1'b0, 4'd3, 8'h00, 13, rd, hold);
        check("rd3_bits", 32'(rd), 32'd0);
        check("rd3_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        LOC_ADDR = 4'd3;
        #1;
        check("rd3_loc", 32'(LOC_DATAO), 32'd0);

        // Write 205 to address 7
        wr_base = wr_cnt;
        frame(1'b1, 4'd7, 8'd205, 13, rd, hold);
        check("wr7_pulses", 32'(wr_cnt - wr_base), 32'd1);
        check("wr7_single", 32'(stb_multi), 32'd0);
        check("wr7_addr", 32'(last_wa), 32'd7);
        check("wr7_data", 32'(last_wd), 32'd205);
        check("wr7_miso", 32'(MISO), 32'd0);
        LOC_ADDR = 4'd7;
        #1;
        check("wr7_loc", 32'(LOC_DATAO), 32'd205);

        // Read address 7 back over MISO
        wr_base = wr_cnt;
        fe_base = fe_cnt;
        frame(1'b0, 4'd7, 8'h00, 13, rd, hold);
        check("rd7_bits", 32'(rd), 32'd205);
        check("rd7_hold_lsb", 32'(hold), 32'd1);
        check("rd7_miso_idle", 32'(MISO), 32'd0);
        check("rd7_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        check("rd7_no_ferr", 32'(fe_cnt - fe_base), 32'd0);

        // Write 0xAA to address 2, aborted after 5 data bits
        wr_base = wr_cnt;
        fe_base = fe_cnt;
        frame(1'b1, 4'd2, 8'hAA, 10, rd, hold);
        check("abort_ferr", 32'(fe_cnt - fe_base), 32'd1);
        check("abort_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        LOC_ADDR = 4'd2;
        #1;
        check("abort_loc2", 32'(LOC_DATAO), 32'd0);

        // Read of address 7 aborted after 3 data bits: MISO released to 0
        fe_base = fe_cnt;
        frame(1'b0, 4'd7, 8'h00, 8, rd, hold);
        check("rdabort_bits", 32'(rd), 32'h6);
        check("rdabort_ferr", 32'(fe_cnt - fe_base), 32'd1);
        check("rdabort_miso", 32'(MISO), 32'd0);

        // Back-to-back writes, 20 clocks of SS high between them
        wr_base = wr_cnt;
        frame(1'b1, 4'd1, 8'h11, 13, rd, hold);
        frame(1'b1, 4'd2, 8'h22, 13, rd, hold);
        check("b2b_pulses", 32'(wr_cnt - wr_base), 32'd2);
        check("b2b_last_addr", 32'(last_wa), 32'd2);
        LOC_ADDR = 4'd1;
        #1;
        check("b2b_loc1", 32'(LOC_DATAO), 32'h11);
        LOC_ADDR = 4'd2;
        #1;
        check("b2b_loc2", 32'(LOC_DATAO), 32'h22);

        // Reset in the middle of a write with SS held low
        wr_base = wr_cnt;
        fe_base = fe_cnt;
        SS = 1'b0;
        clks(5);
        spi_bits({1'b1, 4'd5, 8'h5A}, 0, 5, rd);
        RESET_N = 1'b0;
        clks(2);
        RESET_N = 1'b1;
        clks(2);
        spi_bits({1'b1, 4'd5, 8'h5A}, 6, 12, rd);
        SS = 1'b1;
        clks(20);
        check("rstmid_no_wr", 32'(wr_cnt - wr_base), 32'd0);
        check("rstmid_no_ferr", 32'(fe_cnt - fe_base), 32'd0);
        LOC_ADDR = 4'd5;
        #1;
        check("rstmid_loc5", 32'(LOC_DATAO), 32'd0);
        LOC_ADDR = 4'd7;
        #1;
        check("rstmid_loc7_cleared", 32'(LOC_DATAO), 32'd0);

        wr_base = wr_cnt;
        frame(1'b1, 4'd5, 8'h5A, 13, rd, hold);
        check("post_rst_pulses", 32'(wr_cnt - wr_base), 32'd1);
        check("post_rst_data", 32'(last_wd), 32'h5A);
        LOC_ADDR = 4'd5;
        #1;
        check("post_rst_loc5", 32'(LOC_DATAO), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
